// File: rtl/pkt_tx.sv
// pkt_tx: packet transmitter that writes framed packets into the priority fifo.
// A command (length, priority) is accepted in IDLE. The block waits for fifo
// ready, emits a header word with wr_sop, then streams the payload words from
// the source with wr_eop on the last one. A fixed idle gap follows every packet.
module pkt_tx #(
    parameter int  data_width      = 16,
    parameter int  num_of_priority = 8,
    parameter int  max_len         = 32,
    parameter int  gap_cycles      = 2,
    localparam int PRI_W = (num_of_priority > 1) ? $clog2(num_of_priority) : 1,
    localparam int LEN_W = (max_len > 1) ? $clog2(max_len) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_vld,
    output logic                  cmd_rdy,
    input  logic [LEN_W-1:0]      cmd_len,
    input  logic [PRI_W-1:0]      cmd_pri,
    input  logic                  src_vld,
    output logic                  src_rdy,
    input  logic [data_width-1:0] src_data,
    input  logic                  ready,
    input  logic                  overflow,
    output logic                  wr_sop,
    output logic                  wr_eop,
    output logic                  wr_vld,
    output logic [data_width-1:0] wr_data,
    output logic                  busy,
    output logic                  err_ovf,
    output logic [15:0]           pkt_cnt
);

    localparam int GAP_W = (gap_cycles > 1) ? $clog2(gap_cycles) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((gap_cycles > 0) ? gap_cycles - 1 : 0);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RDY,
        SOP,
        DATA,
        GAP
    } state_t;

    state_t                state, state_nxt;
    logic [LEN_W-1:0]      len_q, len_nxt;
    logic [PRI_W-1:0]      pri_q, pri_nxt;
    logic [LEN_W-1:0]      rem_q, rem_nxt;
    logic [GAP_W-1:0]      gap_q, gap_nxt;
    logic                  sop_nxt, eop_nxt, vld_nxt;
    logic [data_width-1:0] data_nxt;
    logic [data_width-1:0] header;
    logic                  err_ovf_nxt;
    logic [15:0]           pkt_cnt_nxt;

    // Handshake and status flags come straight from the state register.
    assign cmd_rdy = (state == IDLE);
    assign src_rdy = (state == DATA);
    assign busy    = (state != IDLE);

    // Header word: priority in the top bits, encoded length (words - 1) in the low bits.
    always_comb begin
        header                        = '0;
        header[data_width-1 -: PRI_W] = pri_q;
        header[LEN_W-1:0]             = len_q;
    end

    // Next-state and next-output logic for the framing FSM.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        state_nxt   = state;
        len_nxt     = len_q;
        pri_nxt     = pri_q;
        rem_nxt     = rem_q;
        gap_nxt     = gap_q;
        sop_nxt     = 1'b0;
        eop_nxt     = 1'b0;
        vld_nxt     = 1'b0;
        data_nxt    = wr_data;
        pkt_cnt_nxt = pkt_cnt;
        err_ovf_nxt = err_ovf | (overflow & (state != IDLE));

        case (state)
            IDLE: begin
                if (cmd_vld) begin
                    len_nxt   = cmd_len;
                    pri_nxt   = cmd_pri;
                    rem_nxt   = cmd_len;
                    state_nxt = WAIT_RDY;
                end
            end
            WAIT_RDY: begin
                // ready only gates the start of a packet; it is ignored once framing begins.
                if (ready) begin
                    sop_nxt   = 1'b1;
                    data_nxt  = header;
                    state_nxt = SOP;
                end
            end
            SOP: begin
                state_nxt = DATA;
            end
            DATA: begin
                if (src_vld) begin
                    vld_nxt  = 1'b1;
                    data_nxt = src_data;
                    if (rem_q == '0) begin
                        eop_nxt     = 1'b1;
                        pkt_cnt_nxt = pkt_cnt + 16'd1;
                        gap_nxt     = '0;
                        state_nxt   = (gap_cycles == 0) ? IDLE : GAP;
                    end else begin
                        rem_nxt = rem_q - LEN_W'(1);
                    end
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_nxt = IDLE;
                end else begin
                    gap_nxt = gap_q + GAP_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, packet context and registered write-port outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            len_q   <= '0;
            pri_q   <= '0;
            rem_q   <= '0;
            gap_q   <= '0;
            wr_sop  <= 1'b0;
            wr_eop  <= 1'b0;
            wr_vld  <= 1'b0;
            wr_data <= '0;
            err_ovf <= 1'b0;
            pkt_cnt <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            state   <= state_nxt;
            len_q   <= len_nxt;
            pri_q   <= pri_nxt;
            rem_q   <= rem_nxt;
            gap_q   <= gap_nxt;
            wr_sop  <= sop_nxt;
            wr_eop  <= eop_nxt;
            wr_vld  <= vld_nxt;
            wr_data <= data_nxt;
            err_ovf <= err_ovf_nxt;
            pkt_cnt <= pkt_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_pkt_tx.sv
// tb_pkt_tx: self-checking bench for pkt_tx. A scoreboard of expected header
// and payload words is built from each command; a monitor compares every
// wr_sop / wr_vld cycle against it. Hand sequences cover timing corners.
module tb_pkt_tx;

    localparam int DW    = 16;
    localparam int PRI_W = 3;
    localparam int LEN_W = 5;
    localparam int GAP   = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_vld;
    logic             cmd_rdy;
    logic [LEN_W-1:0] cmd_len;
    logic [PRI_W-1:0] cmd_pri;
    logic             src_vld;
    logic             src_rdy;
    logic [DW-1:0]    src_data;
    logic             ready;
    logic             overflow;
    logic             wr_sop;
    logic             wr_eop;
    logic             wr_vld;
    logic [DW-1:0]    wr_data;
    logic             busy;
    logic             err_ovf;
    logic [15:0]      pkt_cnt;

    pkt_tx #(
        .data_width      (DW),
        .num_of_priority (8),
        .max_len         (32),
        .gap_cycles      (GAP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_vld  (cmd_vld),
        .cmd_rdy  (cmd_rdy),
        .cmd_len  (cmd_len),
        .cmd_pri  (cmd_pri),
        .src_vld  (src_vld),
        .src_rdy  (src_rdy),
        .src_data (src_data),
        .ready    (ready),
        .overflow (overflow),
        .wr_sop   (wr_sop),
        .wr_eop   (wr_eop),
        .wr_vld   (wr_vld),
        .wr_data  (wr_data),
        .busy     (busy),
        .err_ovf  (err_ovf),
        .pkt_cnt  (pkt_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            hdr;
        logic [DW-1:0] data;
        bit            last;
    } out_item_t;

    typedef struct {
        logic [DW-1:0] data;
        int            pre_stall;
    } src_word_t;

    typedef struct {
        int            len;
        int            pri;
        logic [DW-1:0] base;
        logic [DW-1:0] exp_hdr;
    } vec_t;

    out_item_t     exp_q[$];
    src_word_t     src_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            cyc      = 0;
    int            sop_cyc  = 0;
    int            eop_cyc  = 0;
    int            vld_cnt  = 0;
    int            last_vld_cnt = 0;
    logic [DW-1:0] last_hdr = '0;
    bit            have_prev_eop = 1'b0;
    int            pkts_model = 0;
    bit            rand_ready = 1'b0;
    logic          ready_fixed = 1'b1;
    logic          ready_rand  = 1'b1;

    assign ready = rand_ready ? ready_rand : ready_fixed;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Header as defined by the packet format: priority weighted at bit 13, plus words-1.
    function automatic logic [DW-1:0] hdr_of(input int len, input int pri);
        return DW'(pri * 8192 + len);
    endfunction

    // Cycle counter, one step per rising edge.
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Random fifo-ready pattern used in the random phase.
    initial forever begin
        @(negedge clk);
        ready_rand = ($urandom_range(0, 3) != 0);
    end

    // Source model: presents the queue head, honouring per-word stall cycles while in DATA.
    initial begin
        src_word_t w;
        src_vld  = 1'b0;
        src_data = '0;
        forever begin
            @(negedge clk);
            if (src_q.size() == 0) begin
                src_vld = 1'b0;
            end else if (src_q[0].pre_stall > 0) begin
                src_vld = 1'b0;
                if (src_rdy) begin
                    w = src_q[0];
                    w.pre_stall--;
                    src_q[0] = w;
                end
            end else begin
                src_vld  = 1'b1;
                src_data = src_q[0].data;
            end
        end
    end

    // Consume a source word at each handshake edge.
    initial forever begin
        @(posedge clk);
        if (src_vld && src_rdy && src_q.size() > 0) void'(src_q.pop_front());
    end

    // Output monitor / scoreboard.
    initial begin
        out_item_t it;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (wr_sop) begin
                    check("sop_alone", 32'(wr_vld), 0);
                    if (have_prev_eop) check("b2b_spacing", 32'((cyc - eop_cyc - 1) >= GAP + 1), 1);
                    check("sop_expected", 32'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        it = exp_q.pop_front();
                        check("sop_is_header", 32'(it.hdr), 1);
                        check("header", 32'(wr_data), 32'(it.data));
                    end
                    sop_cyc  = cyc;
                    last_hdr = wr_data;
                    vld_cnt  = 0;
                end
                if (wr_vld) begin
                    check("vld_expected", 32'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        it = exp_q.pop_front();
                        check("vld_is_payload", 32'(it.hdr), 0);
                        check("payload", 32'(wr_data), 32'(it.data));
                        check("eop_flag", 32'(wr_eop), 32'(it.last));
                    end
                    vld_cnt++;
                    if (wr_eop) begin
                        last_vld_cnt  = vld_cnt;
                        eop_cyc       = cyc;
                        have_prev_eop = 1'b1;
                    end
                end
                if (wr_eop) check("eop_with_vld", 32'(wr_vld), 1);
            end
        end
    end

    // Queue the expected output and the source words, then perform the command handshake.
    // c0 is the cycle index of the accepting edge.
    task automatic send_pkt(input int len, input int pri, input logic [DW-1:0] base, input bit rnd,
                            input int stall_idx, input int stall_len, output int c0);
        out_item_t it;
        src_word_t w;
        bit        took = 1'b0;
        it.hdr  = 1'b1;
        it.data = hdr_of(len, pri);
        it.last = 1'b0;
        exp_q.push_back(it);
        for (int i = 0; i <= len; i++) begin
            w.data      = rnd ? DW'($urandom) : base + DW'(i);
            w.pre_stall = (i == stall_idx) ? stall_len :
                          (rnd && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            src_q.push_back(w);
            it.hdr  = 1'b0;
            it.data = w.data;
            it.last = (i == len);
            exp_q.push_back(it);
        end
        pkts_model++;
        c0 = 0;
        @(negedge clk);
        cmd_vld = 1'b1;
        cmd_len = LEN_W'(len);
        cmd_pri = PRI_W'(pri);
        for (int k = 0; k < 500; k++) begin
            if (cmd_rdy) begin
                c0   = cyc + 1;
                took = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        cmd_vld = 1'b0;
        check("cmd_accepted", 32'(took), 1);
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        check("drain", 32'(done), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          vecs[5];
        int            c0;
        int            cr;
        bit            found;
        logic          lv[$];
        logic [DW-1:0] ld[$];
        logic          le[$];
        logic          ev[8];
        logic [DW-1:0] ed[8];
        logic          ee[8];
        bit            started;

        vecs[0] = '{len: 3,  pri: 5, base: 16'h00A1, exp_hdr: 16'hA003};
        vecs[1] = '{len: 0,  pri: 0, base: 16'h1234, exp_hdr: 16'h0000};
        vecs[2] = '{len: 31, pri: 7, base: 16'h0100, exp_hdr: 16'hE01F};
        vecs[3] = '{len: 4,  pri: 2, base: 16'h0B00, exp_hdr: 16'h4004};
        vecs[4] = '{len: 15, pri: 1, base: 16'h0C00, exp_hdr: 16'h200F};

        rst      = 1'b1;
        cmd_vld  = 1'b0;
        cmd_len  = '0;
        cmd_pri  = '0;
        overflow = 1'b0;

        // Reset state.
        #22;
        check("rst_sop",     32'(wr_sop), 0);
        check("rst_eop",     32'(wr_eop), 0);
        check("rst_vld",     32'(wr_vld), 0);
        check("rst_data",    32'(wr_data), 0);
        check("rst_busy",    32'(busy), 0);
        check("rst_err_ovf", 32'(err_ovf), 0);
        check("rst_pkt_cnt", 32'(pkt_cnt), 0);
        check("rst_cmd_rdy", 32'(cmd_rdy), 1);
        check("rst_src_rdy", 32'(src_rdy), 0);
        @(negedge clk);
        rst = 1'b0;

        // Overflow while idle must not set the sticky flag.
        @(negedge clk);
        overflow = 1'b1;
        @(negedge clk);
        overflow = 1'b0;
        @(negedge clk);
        check("idle_ovf_ignored", 32'(err_ovf), 0);

        // Table-driven packets with ready high and an always-valid source.
        foreach (vecs[v]) begin
            send_pkt(vecs[v].len, vecs[v].pri, vecs[v].base, 1'b0, -1, 0, c0);
            found = 1'b0;
            for (int k = 0; k < 200; k++) begin
                if (wr_eop) begin
                    found = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            check("eop_seen", 32'(found), 1);
            for (int g = 0; g < GAP; g++) begin
                check("gap_cmd_rdy_low", 32'(cmd_rdy), 0);
                @(negedge clk);
                check("gap_no_vld", 32'(wr_vld), 0);
            end
            check("gap_then_cmd_rdy", 32'(cmd_rdy), 1);
            check("tbl_header", 32'(last_hdr), 32'(vecs[v].exp_hdr));
            // sop is registered at the first edge after the accepting edge.
            check("tbl_sop_latency", 32'(sop_cyc - c0), 1);
            check("tbl_vld_count", 32'(last_vld_cnt), 32'(vecs[v].len + 1));
            check("tbl_pkt_cnt", 32'(pkt_cnt), 32'(pkts_model));
            check("tbl_err_ovf", 32'(err_ovf), 0);
            check("tbl_exp_empty", 32'(exp_q.size()), 0);
        end

        // Source stall: 3 empty cycles before word 3 of a 5-word packet.
        send_pkt(4, 6, 16'h5500, 1'b0, 2, 3, c0);
        started = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (wr_vld) started = 1'b1;
            if (started) begin
                lv.push_back(wr_vld);
                ld.push_back(wr_data);
                le.push_back(wr_eop);
            end
            if (wr_eop) break;
        end
        ev = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        ed = '{16'h5500, 16'h5501, 16'h5501, 16'h5501, 16'h5501, 16'h5502, 16'h5503, 16'h5504};
        ee = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        check("stall_len", 32'(lv.size()), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < lv.size()) begin
                check("stall_vld",  32'(lv[i]), 32'(ev[i]));
                check("stall_data", 32'(ld[i]), 32'(ed[i]));
                check("stall_eop",  32'(le[i]), 32'(ee[i]));
            end
        end
        wait_idle();

        // Ready gating with a maximum-length packet.
        ready_fixed = 1'b0;
        send_pkt(31, 3, 16'h3000, 1'b0, -1, 0, c0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("wait_busy", 32'(busy), 1);
            check("wait_no_sop", 32'(wr_sop), 0);
        end
        ready_fixed = 1'b1;
        cr = cyc;
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (wr_sop) begin
                found = 1'b1;
                check("sop_after_ready", 32'(cyc), 32'(cr + 1));
                break;
            end
        end
        check("sop_seen", 32'(found), 1);
        wait_idle();
        check("max_vld_count", 32'(last_vld_cnt), 32);
        check("max_pkt_cnt", 32'(pkt_cnt), 32'(pkts_model));

        // Random back-to-back packets with random ready and source stalls.
        rand_ready = 1'b1;
        for (int n = 0; n < 30; n++) begin
            send_pkt(($urandom_range(0, 3) == 0) ? 31 : int'($urandom_range(0, 7)),
                     int'($urandom_range(0, 7)), '0, 1'b1, -1, 0, c0);
        end
        wait_idle();
        rand_ready = 1'b0;
        check("rand_pkt_cnt", 32'(pkt_cnt), 32'(pkts_model));
        check("rand_err_ovf", 32'(err_ovf), 0);
        check("rand_src_empty", 32'(src_q.size()), 0);

        // Overflow mid-packet: flag is sticky and the packet still completes.
        send_pkt(7, 4, 16'h7700, 1'b0, -1, 0, c0);
        for (int k = 0; k < 50; k++) begin
            if (wr_vld) break;
            @(negedge clk);
        end
        overflow = 1'b1;
        @(negedge clk);
        overflow = 1'b0;
        check("ovf_set", 32'(err_ovf), 1);
        wait_idle();
        check("ovf_pkt_done", 32'(last_vld_cnt), 8);
        check("ovf_pkt_cnt", 32'(pkt_cnt), 32'(pkts_model));
        send_pkt(2, 1, 16'h8800, 1'b0, -1, 0, c0);
        wait_idle();
        check("ovf_sticky", 32'(err_ovf), 1);
        check("ovf_pkt_cnt2", 32'(pkt_cnt), 32'(pkts_model));

        // Asynchronous reset in the middle of a packet.
        send_pkt(20, 5, 16'h9900, 1'b0, -1, 0, c0);
        for (int k = 0, seen = 0; k < 100 && seen < 4; k++) begin
            @(negedge clk);
            if (wr_vld) seen++;
        end
        #2;
        rst = 1'b1;
        #1;
        check("arst_sop",     32'(wr_sop), 0);
        check("arst_eop",     32'(wr_eop), 0);
        check("arst_vld",     32'(wr_vld), 0);
        check("arst_data",    32'(wr_data), 0);
        check("arst_busy",    32'(busy), 0);
        check("arst_err_ovf", 32'(err_ovf), 0);
        check("arst_pkt_cnt", 32'(pkt_cnt), 0);
        exp_q.delete();
        src_q.delete();
        pkts_model    = 0;
        have_prev_eop = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("arst_no_eop", 32'(wr_eop), 0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_cmd_rdy", 32'(cmd_rdy), 1);
        check("post_rst_pkt_cnt", 32'(pkt_cnt), 0);
        send_pkt(1, 2, 16'hC000, 1'b0, -1, 0, c0);
        wait_idle();
        check("post_rst_pkt", 32'(pkt_cnt), 1);
        check("post_rst_err_ovf", 32'(err_ovf), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
